// File: rtl/aes_cypher_uart_tx.sv
// UART 8N1 transmitter that sends one latched ciphertext as uppercase ASCII hex
// (MSB nibble first), followed by CR LF. TxD, busy and done are all registered.
module aes_cypher_uart_tx #(
  parameter int CYPHER_SIZE = 128,
  parameter int BAUD_DIV    = 5208,
  parameter int CONTER_BITS = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CYPHER_SIZE-1:0] cypher_in,
  output logic                   busy,
  output logic                   done,
  output logic                   TxD,
  output logic [2:0]             o_dbg_state
);

  localparam int NCHAR = CYPHER_SIZE / 4 + 2;
  localparam int IDX_W = $clog2(NCHAR);
  localparam logic [CONTER_BITS-1:0] BAUD_LAST = CONTER_BITS'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NCHAR - 1);
  localparam logic [IDX_W-1:0]       CR_IDX    = IDX_W'(NCHAR - 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CYPHER_SIZE-1:0]   r_cypher;
  logic [7:0]               r_shift;
  logic [CONTER_BITS-1:0]   r_baud_cnt;
  logic [2:0]               r_bit_idx;
  logic [IDX_W-1:0]         r_char_idx;
  logic                     r_txd;
  logic                     r_busy;
  logic                     r_done;
  logic                     w_bit_end;
  logic                     w_in_frame;

  // ASCII for character idx: hex digits of c, then CR, then LF.
  function automatic logic [7:0] char_at(input logic [CYPHER_SIZE-1:0] c,
                                         input logic [IDX_W-1:0]       idx);
    logic [CYPHER_SIZE-1:0] sh;
    logic [3:0]             nib;
    logic [7:0]             ch;
    int                     pos;
    pos = (idx < CR_IDX) ? int'(idx) : 0;
    sh  = c << (4 * pos);
    nib = sh[CYPHER_SIZE-1 -: 4];
    if (nib < 4'd10) ch = {4'h3, nib};
    else             ch = 8'h37 + {4'h0, nib};
    if (idx == CR_IDX)   ch = 8'h0D;
    if (idx == LAST_IDX) ch = 8'h0A;
    return ch;
  endfunction

  assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
  assign w_in_frame  = (r_state == START_BIT) || (r_state == DATA_BITS) ||
                       (r_state == STOP_BIT);
  assign busy        = r_busy;
  assign done        = r_done;
  assign TxD         = r_txd;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (start) w_next_state = START_BIT;
      START_BIT: if (w_bit_end) w_next_state = DATA_BITS;
      DATA_BITS: if (w_bit_end && (r_bit_idx == 3'd7)) w_next_state = STOP_BIT;
      STOP_BIT: begin
        if (w_bit_end) begin
          if (r_char_idx < LAST_IDX) w_next_state = START_BIT;
          else                       w_next_state = DONE;
        end
      end
      DONE:      w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cypher   <= '0;
      r_shift    <= '0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_char_idx <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_in_frame) r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + CONTER_BITS'(1);
      case (r_state)
        IDLE: begin
          // Accept edge: the start bit goes out on this same edge.
          if (start) begin
            r_cypher   <= cypher_in;
            r_shift    <= char_at(cypher_in, '0);
            r_char_idx <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_txd      <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        START_BIT: begin
          if (w_bit_end) begin
            r_txd     <= r_shift[0];
            r_bit_idx <= '0;
          end
        end
        DATA_BITS: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
              r_txd <= 1'b1;
            end else begin
              r_txd     <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        STOP_BIT: begin
          // Next start bit follows the stop bit with no idle gap.
          if (w_bit_end) begin
            if (r_char_idx < LAST_IDX) begin
              r_char_idx <= r_char_idx + IDX_W'(1);
              r_shift    <= char_at(r_cypher, r_char_idx + IDX_W'(1));
              r_txd      <= 1'b0;
            end else begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
              r_txd  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cypher_uart_tx.sv
// Bench for aes_cypher_uart_tx: a message-level model predicts TxD/busy/done
// for every cycle, and directed tests decode the line back to text.
module tb_aes_cypher_uart_tx;

  localparam int CS      = 128;
  localparam int BD      = 4;
  localparam int CB      = 3;
  localparam int NCHAR   = CS / 4 + 2;
  localparam int MSG_CYC = 10 * NCHAR * BD;
  localparam logic [CS-1:0] FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [CS-1:0] HEXB = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [CS-1:0] SEQ  = 128'h00112233445566778899AABBCCDDEEFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CS-1:0] cypher_in = '0;
  logic          busy;
  logic          done;
  logic          txd;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic rec[$];

  // Expected {txd, busy, done} for each upcoming cycle.
  logic [2:0] exp_q[$];
  logic [2:0] cur = 3'b100;

  always #5 clk = ~clk;

  aes_cypher_uart_tx #(.CYPHER_SIZE(CS), .BAUD_DIV(BD), .CONTER_BITS(CB)) dut (
    .clk(clk), .rst(rst), .start(start), .cypher_in(cypher_in),
    .busy(busy), .done(done), .TxD(txd), .o_dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic check_str(input string name, input string act, input string req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got \"%s\" want \"%s\"", name, act, req);
    end
  endtask

  function automatic logic [7:0] model_char(input logic [CS-1:0] c, input int i);
    string hexdig;
    hexdig = "0123456789ABCDEF";
    if (i == NCHAR - 2) return 8'h0D;
    if (i == NCHAR - 1) return 8'h0A;
    return hexdig.getc(int'(c[CS-1-4*i -: 4]));
  endfunction

  function automatic void push_msg(input logic [CS-1:0] c);
    logic [9:0] fr;
    for (int i = 0; i < NCHAR; i++) begin
      fr = {1'b1, model_char(c, i), 1'b0};
      for (int b = 0; b < 10; b++)
        for (int k = 0; k < BD; k++) exp_q.push_back({fr[b], 1'b1, 1'b0});
    end
    exp_q.push_back(3'b101);
  endfunction

  // Model: a start seen while the line is truly idle launches a whole message.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      cur = 3'b100;
    end else begin
      if (exp_q.size() == 0 && cur == 3'b100 && start) push_msg(cypher_in);
      cur = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b100;
    end
  end

  always @(negedge clk) check("cycle_txd_busy_done", {61'd0, txd, busy, done}, {61'd0, cur});

  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
      rec.push_back(txd);
    end
    if (done) done_cnt++;
  end

  function automatic logic [7:0] rx_byte(input int j);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = rec[j*10*BD + (1+k)*BD + BD/2];
    return b;
  endfunction

  task automatic send(input logic [CS-1:0] c);
    rec.delete();
    busy_cnt  = 0;
    done_cnt  = 0;
    cypher_in = c;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done !== 1'b1 && k < MSG_CYC + 50) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: done not seen, waited %0d cycles, limit %0d", name, k, MSG_CYC + 50);
    end
  endtask

  task automatic finish_msg(input string name);
    wait_done(name);
    @(negedge clk);
    check({name, "_busy_cycles"}, busy_cnt, MSG_CYC);
    check({name, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic check_msg(input string name, input string hex);
    string s = "";
    int    lc = 0;
    logic [7:0] b;
    check({name, "_rec_len"}, rec.size(), MSG_CYC);
    for (int j = 0; j < NCHAR - 2; j++) begin
      b = rx_byte(j);
      s = $sformatf("%s%c", s, b);
      if (b >= 8'h61 && b <= 8'h7A) lc++;
    end
    check_str({name, "_hex_text"}, s, hex);
    check({name, "_cr"}, rx_byte(NCHAR - 2), 8'h0D);
    check({name, "_lf"}, rx_byte(NCHAR - 1), 8'h0A);
    check({name, "_lowercase_count"}, lc, 0);
  endtask

  initial begin
    string      ms;
    logic [39:0] v;

    // Pin the model against hand-derived values.
    ms = "";
    for (int j = 0; j < NCHAR - 2; j++) ms = $sformatf("%s%c", ms, model_char(FIPS, j));
    check_str("model_fips_text", ms, "69C4E0D86A7B0430D8CDB78070B4C55A");
    check("model_char9", model_char(HEXB, 9), 8'h39);
    check("model_charA", model_char(HEXB, 10), 8'h41);
    check("model_charF", model_char(HEXB, 15), 8'h46);

    // 1. reset
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_txd", txd, 1);
    check("idle_busy", busy, 0);

    // 2. FIPS-197 vector
    send(FIPS);
    finish_msg("fips");
    v = '0;
    for (int i = 0; i < 40; i++) v = {v[38:0], rec[i]};
    check("fips_first_frame", v, 40'h00FF0FF00F);
    check_msg("fips", "69C4E0D86A7B0430D8CDB78070B4C55A");
    repeat (5) @(negedge clk);

    // 3. hex digit boundaries
    send(HEXB);
    finish_msg("hexb");
    check_msg("hexb", "0123456789ABCDEFFEDCBA9876543210");
    repeat (5) @(negedge clk);

    // 4. late data change and ignored start
    send(SEQ);
    repeat (5) @(negedge clk);
    cypher_in = ~SEQ;
    repeat (195) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_msg("ignored_start");
    check_msg("ignored_start", "00112233445566778899AABBCCDDEEFF");
    repeat (5) @(negedge clk);

    // 5. reset during data bit 3 of char 10 ('7', bit3 = 0)
    send(FIPS);
    repeat (417) @(posedge clk);
    #1;
    check("midrst_pre_txd", txd, 0);
    check("midrst_pre_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send(FIPS);
    finish_msg("after_rst");
    check_msg("after_rst", "69C4E0D86A7B0430D8CDB78070B4C55A");
    repeat (5) @(negedge clk);

    // 6. start held high: back-to-back messages
    rec.delete();
    busy_cnt  = 0;
    done_cnt  = 0;
    cypher_in = SEQ;
    start     = 1'b1;
    wait_done("held1");
    @(negedge clk);
    check("held_gap_busy", busy, 0);
    check("held_gap_txd", txd, 1);
    check("held_gap_done", done, 0);
    check("held_first_done_pulses", done_cnt, 1);
    @(negedge clk);
    check("held_restart_busy", busy, 1);
    check("held_restart_txd", txd, 0);
    start = 1'b0;
    wait_done("held2");
    @(negedge clk);
    check("held_total_done_pulses", done_cnt, 2);
    check("held_total_busy", busy_cnt, 2 * MSG_CYC);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_cypher_uart_tx.md
Name: aes_cypher_uart_tx

Overview:
- Transmit side for ciphertext leaving the AES core.
- Captures one CYPHER_SIZE-bit ciphertext on a start request.
- Serialises it over a UART TX line (8N1) as uppercase ASCII hex, MSB nibble first, followed by CR LF, for capture by the lab PC.
- Sits between the AES_Encrypt cypher output and the board's TxD pin, on the same clock as the AES core.

Parameters:
- CYPHER_SIZE, 128, ciphertext width in bits; must be a multiple of 4.
- BAUD_DIV, 5208, clk cycles per UART bit (9600 baud at 50 MHz).
- CONTER_BITS, 13, width of the baud counter; must satisfy 2^CONTER_BITS > BAUD_DIV.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- start  input  1  transmit request; level-sampled every clk.
- cypher_in  input  CYPHER_SIZE  ciphertext to send; sampled only on the accepting cycle.
- busy  output  1  high from the accept edge until the message completes.
- done  output  1  one-cycle pulse when the final stop bit has ended.
- TxD  output  1  UART serial line; idle high.

Behaviour:
- Reset (rst=0, asynchronous): TxD=1, busy=0, done=0, state=IDLE, all counters and the shift register cleared. Reset asserted mid-frame forces TxD=1 immediately; the message is abandoned and no done pulse is produced.
- Message format: NCHAR = CYPHER_SIZE/4 + 2 characters (34 at default).
  - Nibble i = cypher[CYPHER_SIZE-1-4i -: 4], i = 0 .. CYPHER_SIZE/4-1.
  - Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
  - The hex characters are followed by 0x0D then 0x0A.
- Frame: 1 start bit (0), 8 data bits sent LSB first, 1 stop bit (1). Each bit is held exactly BAUD_DIV clk cycles. There is no idle gap between characters: the next start bit follows the stop bit directly.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, DONE.
  - IDLE -> START_BIT when start=1 at a rising edge. On that same edge: cypher_in is latched, busy goes to 1, the char index is set to 0, the current char is loaded, and TxD goes to 0.
  - START_BIT -> DATA_BITS after BAUD_DIV cycles.
  - DATA_BITS: shifts out 8 bits; bit index 0..7, each bit BAUD_DIV cycles. Goes to STOP_BIT after bit 7.
  - STOP_BIT: lasts BAUD_DIV cycles.
    - If the char index is below NCHAR-1: increment the index, load the next char, return to START_BIT.
    - Otherwise: go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, TxD=1; then IDLE.
- Latency: first TxD falling edge is 0 cycles after the accept edge (registered on that edge). Total busy time = 10*NCHAR*BAUD_DIV cycles (340*BAUD_DIV at default). done is asserted on the cycle immediately following that.
- The baud counter counts 0..BAUD_DIV-1 and wraps to 0 at each bit boundary. It is reset to 0 on accept.
- start while busy=1, including the DONE cycle, is ignored. A start held high continuously re-triggers on the first IDLE cycle after DONE, i.e. one cycle of idle-high TxD between messages.
- cypher_in changes after the accept edge have no effect on the message in flight.
- TxD is driven directly from a register, so it is glitch-free.

Test Plan (bench uses BAUD_DIV=4, CONTER_BITS=3):
1. Reset: hold rst=0 for 3 cycles -> TxD=1, busy=0, done=0. Release rst with start=0 for 100 cycles -> outputs unchanged.
2. FIPS-197 vector: cypher_in=128'h69c4e0d86a7b0430d8cdb78070b4c55a, start pulsed 1 cycle.
   - Decoded bytes must be "69C4E0D86A7B0430D8CDB78070B4C55A" followed by 0x0D 0x0A.
   - First frame: TxD sequence 0,0,1,1,0,1,1,0,0,1, each level held 4 cycles.
   - busy high for 1360 cycles; done high exactly 1 cycle.
3. Hex boundary: cypher_in=128'h0123456789ABCDEFFEDCBA9876543210 -> chars include 0x39 for '9' and 0x41 for 'A', and 0x46 for 'F'. No lowercase characters appear.
4. Ignored start and late data:
   - Assert start again at cycle 200 of an active message -> no restart; total busy still 1360 cycles.
   - Change cypher_in at cycle 5 -> transmitted data unchanged.
5. Reset mid-frame: drop rst during data bit 3 of char 10 -> TxD=1 and busy=0 asynchronously, with no done pulse. Re-release rst and start -> a fresh, complete 34-character message follows.
6. start held high: two back-to-back messages. Exactly one done pulse between them, followed by one idle-high cycle before the second start bit.
